// File: rtl/serial_sub_pkg.sv
// Shared constants for the bit-serial subtractor: FSM encodings and default width.
package serial_sub_pkg;

    localparam int SS_WIDTH_DEFAULT = 4;

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_SHIFT = 2'd1;
    localparam logic [1:0] ST_DONE  = 2'd2;

endpackage

// File: rtl/serial_subtractor_full_subtractor.sv
// Gate-level full subtractor built from two half subtractors,
// mirroring the half/full adder split of the ripple-carry adder.
module half_subtractor (
    output logic d,
    output logic bo,
    input  logic x,
    input  logic y
);

    logic w_nx;

    xor g_d  (d, x, y);
    not g_nx (w_nx, x);
    and g_bo (bo, w_nx, y);

endmodule

module full_subtractor (
    output logic d,
    output logic bo,
    input  logic x,
    input  logic y,
    input  logic bi
);

    logic w_d0;
    logic w_b0;
    logic w_b1;

    half_subtractor u_hs0 (
        .d  (w_d0),
        .bo (w_b0),
        .x  (x),
        .y  (y)
    );

    half_subtractor u_hs1 (
        .d  (d),
        .bo (w_b1),
        .x  (w_d0),
        .y  (bi)
    );

    or g_bo (bo, w_b0, w_b1);

endmodule

// File: rtl/serial_subtractor.sv
// Bit-serial a - b - bin, LSB first, one full-subtractor slice plus borrow flop.
// Define SERIAL_SUB_SIGNED_EN to add the signed-overflow output ovf.
module serial_subtractor
    import serial_sub_pkg::*;
#(
    parameter int WIDTH = SS_WIDTH_DEFAULT
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             bin,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] diff,
    output logic             bout,
    output logic             zero
`ifdef SERIAL_SUB_SIGNED_EN
    ,
    output logic             ovf
`endif
);

    localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

    logic [1:0]       r_state;
    logic [CW-1:0]    r_cnt;
    logic [WIDTH-1:0] r_a_sh;
    logic [WIDTH-1:0] r_b_sh;
    logic             r_br;
`ifdef SERIAL_SUB_SIGNED_EN
    logic             r_sa;
    logic             r_sb;
`endif

    logic             w_d;
    logic             w_bo;
    logic             w_last;
    logic [WIDTH-1:0] w_res;

    full_subtractor u_fs (
        .d  (w_d),
        .bo (w_bo),
        .x  (r_a_sh[0]),
        .y  (r_b_sh[0]),
        .bi (r_br)
    );

    // Minuend bits retire from the LSB while difference bits enter at the
    // MSB, so after WIDTH shifts this register holds the full result.
    assign w_res  = {w_d, r_a_sh[WIDTH-1:1]};
    assign w_last = (r_cnt == LAST);
    assign busy   = (r_state == ST_SHIFT);
    assign done   = (r_state == ST_DONE);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= ST_IDLE;
            r_cnt   <= '0;
            r_a_sh  <= '0;
            r_b_sh  <= '0;
            r_br    <= 1'b0;
            diff    <= '0;
            bout    <= 1'b0;
            zero    <= 1'b0;
`ifdef SERIAL_SUB_SIGNED_EN
            r_sa    <= 1'b0;
            r_sb    <= 1'b0;
            ovf     <= 1'b0;
`endif
        end else begin
            unique case (r_state)
                ST_IDLE, ST_DONE: begin
                    if (start) begin
                        r_a_sh  <= a;
                        r_b_sh  <= b;
                        r_br    <= bin;
                        r_cnt   <= '0;
                        r_state <= ST_SHIFT;
`ifdef SERIAL_SUB_SIGNED_EN
                        r_sa    <= a[WIDTH-1];
                        r_sb    <= b[WIDTH-1];
`endif
                    end else begin
                        r_state <= ST_IDLE;
                    end
                end
                ST_SHIFT: begin
                    r_a_sh <= w_res;
                    r_b_sh <= {1'b0, r_b_sh[WIDTH-1:1]};
                    r_br   <= w_bo;
                    r_cnt  <= r_cnt + CW'(1);
                    if (w_last) begin
                        r_state <= ST_DONE;
                        diff    <= w_res;
                        bout    <= w_bo;
                        zero    <= (w_res == '0);
`ifdef SERIAL_SUB_SIGNED_EN
                        ovf     <= (r_sa != r_sb) && (w_d != r_sa);
`endif
                    end
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_serial_subtractor.sv
// Self-checking bench for serial_subtractor (WIDTH=4), scoreboard-based.
// Signed-overflow checks are enabled when SERIAL_SUB_SIGNED_EN is defined.
module tb_serial_subtractor;

    localparam int W = 4;

`ifdef SERIAL_SUB_SIGNED_EN
    localparam logic SG = 1'b1;
`else
    localparam logic SG = 1'b0;
`endif

    typedef struct packed {
        logic         ovf;
        logic         bout;
        logic         zero;
        logic [W-1:0] diff;
    } res_t;

    logic         clk;
    logic         rst;
    logic         start;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         bin;
    logic         busy;
    logic         done;
    logic [W-1:0] diff;
    logic         bout;
    logic         zero;
    logic         ovf_w;

    res_t q[$];
    int   n_checks = 0;
    int   n_pass   = 0;
    int   cyc_n    = 0;

`ifdef SERIAL_SUB_SIGNED_EN
    logic ovf;
    assign ovf_w = ovf;
`else
    assign ovf_w = 1'b0;
`endif

    serial_subtractor #(.WIDTH(W)) dut (
        .clk   (clk),
        .rst   (rst),
        .start (start),
        .a     (a),
        .b     (b),
        .bin   (bin),
        .busy  (busy),
        .done  (done),
        .diff  (diff),
        .bout  (bout),
        .zero  (zero)
`ifdef SERIAL_SUB_SIGNED_EN
        ,
        .ovf   (ovf)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;
    always @(posedge clk) cyc_n <= cyc_n + 1;

    function automatic res_t model(input logic [W-1:0] x, input logic [W-1:0] y,
                                   input logic c);
        logic [W:0] full;
        res_t       r;
        full   = {1'b0, x} - {1'b0, y} - {{W{1'b0}}, c};
        r.diff = full[W-1:0];
        r.bout = full[W];
        r.zero = (r.diff == '0);
        r.ovf  = SG & (x[W-1] != y[W-1]) & (r.diff[W-1] != x[W-1]);
        return r;
    endfunction

    function automatic res_t got();
        return {ovf_w, bout, zero, diff};
    endfunction

    task automatic issue(input logic [W-1:0] x, input logic [W-1:0] y,
                         input logic c, input res_t e);
        @(negedge clk);
        a = x;
        b = y;
        bin = c;
        start = 1'b1;
        q.push_back(e);
        @(posedge clk);
        #1 start = 1'b0;
    endtask

    task automatic wait_done(input int limit, output int cyc, output int nb);
        cyc = -1;
        nb = 0;
        for (int i = 1; i <= limit; i++) begin
            @(negedge clk);
            if (busy) nb++;
            if (done) begin
                cyc = i;
                return;
            end
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        start = 1'b0;
        a = '0;
        b = '0;
        bin = 1'b0;
        repeat (3) @(negedge clk);
        n_checks++;
        if ({busy, done} !== 2'b00)
            $display("FAIL reset_ctrl: got %b expected 00", {busy, done});
        else n_pass++;
        n_checks++;
        if (got() !== res_t'(0))
            $display("FAIL reset_result: got %h expected 0", got());
        else n_pass++;
        rst = 1'b0;
    endtask

    task automatic test_basic();
        logic [W-1:0] ta[6];
        logic [W-1:0] tb[6];
        logic         tc[6];
        res_t         te[6];
        res_t         e;
        int           n;
        int           cyc;
        int           nb;
        ta = '{4'd9, 4'd3, 4'd5, 4'd7, 4'h8, 4'h2};
        tb = '{4'd3, 4'd9, 4'd5, 4'd7, 4'h1, 4'h3};
        tc = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0};
        te = '{{1'b0, 1'b0, 1'b0, 4'h6},
               {SG,   1'b1, 1'b0, 4'hA},
               {1'b0, 1'b1, 1'b0, 4'hF},
               {1'b0, 1'b0, 1'b1, 4'h0},
               {SG,   1'b0, 1'b0, 4'h7},
               {1'b0, 1'b1, 1'b0, 4'hF}};
        n = SG ? 6 : 4;
        for (int i = 0; i < n; i++) begin
            issue(ta[i], tb[i], tc[i], te[i]);
            wait_done(20, cyc, nb);
            n_checks++;
            if (cyc !== W + 1)
                $display("FAIL basic_latency[%0d]: got %0d expected %0d", i, cyc, W + 1);
            else n_pass++;
            n_checks++;
            if (nb !== W)
                $display("FAIL basic_busy_cycles[%0d]: got %0d expected %0d", i, nb, W);
            else n_pass++;
            n_checks++;
            if (busy !== 1'b0)
                $display("FAIL basic_busy_at_done[%0d]: got %b expected 0", i, busy);
            else n_pass++;
            e = q.pop_front();
            n_checks++;
            if (got() !== e)
                $display("FAIL basic_result[%0d]: got %h expected %h", i, got(), e);
            else n_pass++;
        end
    endtask

    task automatic test_ignore_start();
        res_t e;
        int   cyc;
        int   nb;
        int   nd;
        issue(4'd9, 4'd3, 1'b0, {1'b0, 1'b0, 1'b0, 4'h6});
        @(negedge clk);
        @(negedge clk);
        a = 4'd1;
        b = 4'd1;
        start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        wait_done(20, cyc, nb);
        n_checks++;
        if (cyc < 0)
            $display("FAIL ignore_done: got timeout expected done");
        else n_pass++;
        e = q.pop_front();
        n_checks++;
        if (got() !== e)
            $display("FAIL ignore_result: got %h expected %h", got(), e);
        else n_pass++;
        nd = 0;
        repeat (3 * W) begin
            @(negedge clk);
            if (done) nd++;
        end
        n_checks++;
        if (nd !== 0)
            $display("FAIL ignore_extra_done: got %0d expected 0", nd);
        else n_pass++;
    endtask

    task automatic test_back_to_back();
        res_t e;
        int   t1;
        int   t2;
        int   cyc;
        int   nb;
        @(negedge clk);
        a = 4'd9;
        b = 4'd3;
        bin = 1'b0;
        start = 1'b1;
        q.push_back({1'b0, 1'b0, 1'b0, 4'h6});
        @(posedge clk);
        #1;
        a = 4'd0;
        b = 4'd1;
        q.push_back({1'b0, 1'b1, 1'b0, 4'hF});
        wait_done(20, cyc, nb);
        t1 = cyc_n;
        e = q.pop_front();
        n_checks++;
        if (got() !== e)
            $display("FAIL b2b_first: got %h expected %h", got(), e);
        else n_pass++;
        @(posedge clk);
        #1 start = 1'b0;
        @(negedge clk);
        n_checks++;
        if ({busy, diff} !== {1'b1, 4'h6})
            $display("FAIL b2b_hold: got %b/%h expected 1/6", busy, diff);
        else n_pass++;
        wait_done(20, cyc, nb);
        t2 = cyc_n;
        n_checks++;
        if (t2 - t1 !== W + 1)
            $display("FAIL b2b_spacing: got %0d expected %0d", t2 - t1, W + 1);
        else n_pass++;
        e = q.pop_front();
        n_checks++;
        if (got() !== e)
            $display("FAIL b2b_second: got %h expected %h", got(), e);
        else n_pass++;
    endtask

    task automatic test_reset_mid();
        res_t e;
        res_t dropped;
        int   nd;
        int   cyc;
        int   nb;
        issue(4'd9, 4'd3, 1'b0, {1'b0, 1'b0, 1'b0, 4'h6});
        repeat (3) @(negedge clk);
        #2 rst = 1'b1;
        #1;
        n_checks++;
        if ({busy, done} !== 2'b00)
            $display("FAIL midrst_ctrl: got %b expected 00", {busy, done});
        else n_pass++;
        n_checks++;
        if (got() !== res_t'(0))
            $display("FAIL midrst_result: got %h expected 0", got());
        else n_pass++;
        dropped = q.pop_back();
        #1 rst = 1'b0;
        nd = 0;
        repeat (2 * W) begin
            @(negedge clk);
            if (done) nd++;
        end
        n_checks++;
        if (nd !== 0)
            $display("FAIL midrst_no_done: got %0d expected 0 (dropped %h)", nd, dropped);
        else n_pass++;
        issue(4'd9, 4'd3, 1'b0, {1'b0, 1'b0, 1'b0, 4'h6});
        wait_done(20, cyc, nb);
        n_checks++;
        if (cyc !== W + 1)
            $display("FAIL midrst_latency: got %0d expected %0d", cyc, W + 1);
        else n_pass++;
        e = q.pop_front();
        n_checks++;
        if (got() !== e)
            $display("FAIL midrst_result_after: got %h expected %h", got(), e);
        else n_pass++;
    endtask

    task automatic test_random();
        logic [W-1:0] x;
        logic [W-1:0] y;
        logic         c;
        res_t         e;
        int           cyc;
        int           nb;
        for (int i = 0; i < 300; i++) begin
            x = W'($urandom);
            y = W'($urandom);
            c = 1'($urandom);
            repeat ($urandom_range(0, 2)) @(negedge clk);
            issue(x, y, c, model(x, y, c));
            wait_done(20, cyc, nb);
            e = q.pop_front();
            n_checks++;
            if (cyc < 0 || got() !== e)
                $display("FAIL random[%0d] %h-%h-%b: got %h expected %h (cyc %0d)",
                         i, x, y, c, got(), e, cyc);
            else n_pass++;
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_ignore_start();
        test_back_to_back();
        test_reset_mid();
        test_random();
        n_checks++;
        if (q.size() !== 0)
            $display("FAIL scoreboard_empty: got %0d expected 0", q.size());
        else n_pass++;
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
